// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and mode constants for the pwm envelope path.
//   ramp_state_e : IDLE / UP / DOWN / DONE, 2-bit encoding
//   MODE_SAW     : sawtooth shape select (mode = 0)
//   MODE_TRI     : triangle shape select (mode = 1)
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_DONE = 2'd3
   } ramp_state_e;

   localparam logic MODE_SAW = 1'b0;
   localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running PWM period counter with boundary-only reload.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   period_in    : requested period in cycles, 0 treated as 1
//   duty         : period currently in force (reloaded only at the wrap edge)
//   period_start : high in the first cycle of each period
//   wrap         : high in the last cycle of each period (next edge is the boundary)
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] period_in,
   output logic [W-1:0] duty,
   output logic         period_start,
   output logic         wrap
);

   logic [W-1:0] pcnt_q, pcnt_d;
   logic [W-1:0] duty_q, duty_d;

   // pcnt never exceeds duty_q-1 because duty only changes as pcnt returns to 0
   always_comb begin
      wrap   = (pcnt_q == duty_q - W'(1));
      pcnt_d = wrap ? '0 : pcnt_q + W'(1);
      duty_d = wrap ? ((period_in == '0) ? W'(1) : period_in) : duty_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q <= '0;
         duty_q <= W'(1);
      end else begin
         pcnt_q <= pcnt_d;
         duty_q <= duty_d;
      end
   end

   assign duty         = duty_q;
   assign period_start = (pcnt_q == '0);

endmodule

// File: rtl/pwm_ramp.sv
// pwm_ramp: amplitude envelope generator feeding a downstream pwm.
// Steps ampl between lo and hi (sawtooth or triangle), holding each value for
// hold+1 whole periods; every update lands on a period boundary.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   en           : run enable, sampled only at period boundaries
//   period_in    : requested PWM period (0 treated as 1)
//   lo, hi       : amplitude bounds (lo > hi collapses to constant lo)
//   step         : amplitude increment per step
//   hold         : extra periods per step
//   mode         : MODE_SAW / MODE_TRI
//   ampl, duty   : to pwm ampl / duty
//   period_start : first cycle of each period
//   busy         : state is not IDLE
//   done         : only with PWM_RAMP_ONESHOT_EN, high in DONE
// Optional feature macro: PWM_RAMP_ONESHOT_EN (single sweep then DONE).
module pwm_ramp
   import pwm_pkg::*;
#(
   parameter int XLEN   = 3,
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [XLEN:0]     period_in,
   input  logic [XLEN-1:0]   lo,
   input  logic [XLEN-1:0]   hi,
   input  logic [XLEN-1:0]   step,
   input  logic [HOLD_W-1:0] hold,
   input  logic              mode,
   output logic [XLEN-1:0]   ampl,
   output logic [XLEN:0]     duty,
   output logic              period_start,
   output logic              busy
`ifdef PWM_RAMP_ONESHOT_EN
   ,
   output logic              done
`endif
);

   ramp_state_e       state_q, state_d;
   logic [XLEN-1:0]   ampl_q, ampl_d;
   logic [HOLD_W-1:0] hcnt_q, hcnt_d;
   logic              wrap;
   logic [XLEN-1:0]   eff_hi, up_val, dn_val;
   logic [XLEN:0]     up_sum, dn_dif;
   logic              at_hi, at_lo;

   pwm_period_timer #(.W(XLEN + 1)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .period_in    (period_in),
      .duty         (duty),
      .period_start (period_start),
      .wrap         (wrap)
   );

   always_comb begin
      eff_hi = (lo > hi) ? lo : hi;
      // one extra bit catches both the carry of the up step and the borrow of the down step
      up_sum = {1'b0, ampl_q} + {1'b0, step};
      up_val = (up_sum > {1'b0, eff_hi}) ? eff_hi : up_sum[XLEN-1:0];
      dn_dif = {1'b0, ampl_q} - {1'b0, step};
      dn_val = (dn_dif[XLEN] || dn_dif[XLEN-1:0] < lo) ? lo : dn_dif[XLEN-1:0];
      at_hi  = (ampl_q >= eff_hi);
      at_lo  = (ampl_q <= lo);
      state_d = state_q;
      ampl_d  = ampl_q;
      hcnt_d  = hcnt_q;
      if (wrap) begin
         if (!en) begin
            state_d = ST_IDLE;
            ampl_d  = '0;
            hcnt_d  = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_UP;
                  ampl_d  = lo;
                  hcnt_d  = '0;
               end
               ST_UP, ST_DOWN: begin
                  if (hcnt_q < hold) begin
                     hcnt_d = hcnt_q + HOLD_W'(1);
                  end else begin
                     hcnt_d = '0;
                     if (state_q == ST_UP) begin
                        if (!at_hi) begin
                           ampl_d = up_val;
                        end else if (mode == MODE_SAW) begin
`ifdef PWM_RAMP_ONESHOT_EN
                           state_d = ST_DONE;
`else
                           ampl_d = lo;
`endif
                        end else begin
                           // top of the triangle: turn around within the same step
                           state_d = ST_DOWN;
                           ampl_d  = dn_val;
                        end
                     end else begin
                        if (!at_lo) begin
                           ampl_d = dn_val;
                        end else begin
`ifdef PWM_RAMP_ONESHOT_EN
                           state_d = ST_DONE;
`else
                           state_d = ST_UP;
                           ampl_d  = up_val;
`endif
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ampl_q  <= '0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ampl_q  <= ampl_d;
         hcnt_q  <= hcnt_d;
      end
   end

   assign ampl = ampl_q;
   assign busy = (state_q != ST_IDLE);
`ifdef PWM_RAMP_ONESHOT_EN
   assign done = (state_q == ST_DONE);
`endif

endmodule

// File: doc/pwm_ramp.md
Name: pwm_ramp

Overview:
- Envelope generator directly upstream of pwm; drives its ampl and duty inputs.
- Steps amplitude between programmable low/high bounds, in sawtooth or triangle shape.
- Holds each amplitude for a programmable number of whole PWM periods.
- Updates ampl/duty only at period boundaries, so pwm never sees a mid-period change; reset together with pwm, its period counter stays phase-aligned.

Parameters:
XLEN, 3, amplitude width; duty is XLEN+1 bits, matching pwm.
HOLD_W, 4, width of the hold (periods-per-step) input.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
en  input  1  run enable, level.
period_in  input  XLEN+1  requested PWM period in cycles; 0 treated as 1.
lo  input  XLEN  lower amplitude bound.
hi  input  XLEN  upper amplitude bound.
step  input  XLEN  amplitude increment per step; 0 = constant amplitude.
hold  input  HOLD_W  extra periods per step; 0 = step every period.
mode  input  1  0 = sawtooth, 1 = triangle.
ampl  output  XLEN  to pwm ampl.
duty  output  XLEN+1  to pwm duty.
period_start  output  1  high in the first cycle of each period.
busy  output  1  high when not IDLE.

Behaviour:
- Reset (rst=0, async):
  - ampl=0; duty=1; period_start=1; busy=0.
  - Period counter pcnt=0; hold counter hcnt=0; state=IDLE.
- Period counter:
  - pcnt counts 0..duty-1, then wraps to 0.
  - period_start = (pcnt==0).
  - duty reloads from max(period_in,1) only on the edge that wraps pcnt to 0.
  - A period_in change mid-period takes effect at the next period.
- Boundary edge: the edge where pcnt wraps. All ampl/state/hcnt updates happen only here, so new ampl is valid from the first cycle of the new period.
- Effective bounds: eff_hi = max(lo,hi); lo>hi clamps to constant lo.
- Step arithmetic:
  - Computed in XLEN+1 bits.
  - Up: min(ampl+step, eff_hi). Down: max(ampl-step, lo), with borrow detected.
- States:
  - IDLE: ampl=0.
    - en=1 at boundary -> ampl=lo, hcnt=0, go UP.
  - UP: at boundary, if hcnt<hold then hcnt++; else hcnt=0 and step:
    - ampl<eff_hi: ampl=up value.
    - ampl==eff_hi, sawtooth: ampl=lo.
    - ampl==eff_hi, triangle: go DOWN and apply one down step.
  - DOWN: same hold rule.
    - ampl>lo: ampl=down value.
    - ampl==lo: go UP and apply one up step.
  - Any state: en=0 at boundary -> IDLE, ampl=0, hcnt=0. en is ignored between boundaries.
- step=0: ampl stays at lo and the state still alternates per the rules; no lockup.
- lo==hi: ampl constant at lo in both modes.
- Reset mid-operation: outputs return to reset values immediately; restart needs a boundary with en=1.
- busy = (state!=IDLE).

Optional Feature:
- Macro: PWM_RAMP_ONESHOT_EN.
- Defined:
  - Adds state DONE and output done (1 bit, reset 0).
  - Sawtooth: reaching eff_hi enters DONE instead of wrapping.
  - Triangle: returning to lo enters DONE.
  - In DONE: ampl held, done=1, busy=1.
  - en=0 at boundary -> IDLE, done=0.
- Not defined: continuous operation as above; no done port.

Decomposition:
- Shared package pwm_pkg:
  - State encoding IDLE/UP/DOWN/DONE (2 bits).
  - Mode constants MODE_SAW=0, MODE_TRI=1.
- Sub-module pwm_period_timer:
  - Owns pcnt, duty reload and period_start.
  - Reusable by pwm itself.
- The state machine and arithmetic stay in pwm_ramp.

Test Plan:
- Reset with period_in=7, en=0 -> ampl=0, duty=1, busy=0.
  - Then for 20 cycles: ampl stays 0, period_start pulses every cycle until duty reloads to 7, then every 7th cycle.
- Sawtooth: lo=1, hi=4, step=1, hold=0, period_in=7, en=1 -> ampl sequence per period 1,2,3,4,1,2...
  - ampl changes only in cycles where period_start=1.
  - Downstream pwm shows 1,2,3,4 high cycles out of 7.
- Triangle: lo=0, hi=6, step=2, hold=1 -> each value held 2 periods; sequence 0,0,2,2,4,4,6,6,4,4,2,2,0,0,2...
- Bounds: lo=5, hi=2 -> ampl constant 5. step=3, lo=0, hi=7 sawtooth -> 0,3,6,7,0.
- Mid-run: en=0 mid-period -> ampl unchanged until next boundary, then 0, busy=0.
  - rst asserted mid-period -> ampl=0 immediately.
  - period_in 7->3 mid-period -> the current period completes at 7, the next period is 3.
- With PWM_RAMP_ONESHOT_EN, sawtooth lo=1, hi=3, step=1 -> 1,2,3 then done=1, ampl holds 3; en=0 -> done=0, ampl=0.
